jk_excite_driver: RTL and testbench

- Driver side of the JK flip-flop interface. It accepts a stream of desired next-state bits over a valid/ready handshake and buffers them in a FIFO.
- Each cycle it pops one target and drives registered j/k excitation so that a downstream jkff produces exactly that q sequence.
- A shadow model of the flop's q is checked against the real q fed back, giving self-checking stimulus for JK-flop testbenches and SoC use.

---
 rtl/jk_excite_driver.sv | 170 +++++++++++++++++
 tb/tb_jk_excite_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_driver.sv
// jk_excite_driver
//   Driver side of a JK flip-flop link. Desired q bits arrive over a
//   valid/ready handshake and sit in a DEPTH-entry FIFO. In DRIVE the head
//   is popped once per cycle and turned into registered j/k excitation,
//   computed against a shadow copy of the flop's q (q_exp). The real q is
//   fed back on q_fb and compared with q_exp every cycle.
//
// Parameters
//   DEPTH       FIFO entries (power of 2, >= 2)
//   TOGGLE_MODE value used for don't-care j/k bits (0: hold/set/reset codes,
//               1: toggle codes)
//   HALT_ON_ERR 1: stop driving on a q mismatch; 0: count it and carry on
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   en                   run enable
//   tgt_valid/tgt_ready  target handshake, tgt_bit is the desired q
//   q_fb                 real flop q
//   clr_err              pulse: clear err, resync q_exp to q_fb
//   j, k, drive_valid    registered excitation, valid when carrying a target
//   err, err_cnt         sticky mismatch flag, saturating mismatch count
//   level                FIFO occupancy
//
// Optional build macro JK_DRV_COVER_EN adds cov_hold/cov_rst/cov_set/cov_tog,
// 16-bit saturating counts of driven j/k codes 00/01/10/11.
module jk_excite_driver #(
  parameter int DEPTH       = 8,
  parameter int TOGGLE_MODE = 0,
  parameter int HALT_ON_ERR = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic                     tgt_bit,
  input  logic                     q_fb,
  input  logic                     clr_err,
  output logic                     j,
  output logic                     k,
  output logic                     drive_valid,
  output logic                     err,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   level
`ifdef JK_DRV_COVER_EN
  ,
  output logic [15:0]              cov_hold,
  output logic [15:0]              cov_rst,
  output logic [15:0]              cov_set,
  output logic [15:0]              cov_tog
`endif
);

  localparam int   AW = $clog2(DEPTH);
  localparam logic DC = (TOGGLE_MODE != 0);
  localparam logic [AW:0] FULL_LVL = AW'(0) + (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, HALT} st_t;

  st_t            st, st_nxt;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]  wp, rp;
  logic           q_exp, q_jk, q_nxt;
  logic           full, empty, push, pop, mis, halt_now;
  logic           t, j_nxt, k_nxt, dv_nxt;

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign tgt_ready = !full;
  // Full blocks the push even if the head leaves on the same edge.
  assign push      = tgt_valid && !full;
  assign mis       = (q_fb != q_exp);
  assign halt_now  = !clr_err && mis && (HALT_ON_ERR != 0);
  assign t         = mem[rp];

  // JK rule applied to the excitation currently on the wire.
  always_comb begin
    q_jk = q_exp;
    case ({j, k})
      2'b01:   q_jk = 1'b0;
      2'b10:   q_jk = 1'b1;
      2'b11:   q_jk = !q_exp;
      default: q_jk = q_exp;
    endcase
  end

  // A resync replaces the model's next value, so encode against it too.
  assign q_nxt = clr_err ? q_fb : q_jk;

  always_comb begin
    st_nxt = st;
    pop    = 1'b0;
    if (halt_now) begin
      st_nxt = HALT;
    end else begin
      case (st)
        IDLE:    if (en) st_nxt = DRIVE;
        DRIVE:   if (!en) st_nxt = IDLE;
                 else if (!empty) pop = 1'b1;
        HALT:    if (clr_err) st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end
    j_nxt  = 1'b0;
    k_nxt  = 1'b0;
    dv_nxt = pop;
    if (pop) begin
      // From 0 only j matters, from 1 only k matters; the other is DC.
      j_nxt = q_nxt ? DC : t;
      k_nxt = q_nxt ? !t : DC;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= IDLE;
      mem         <= '0;
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      q_exp       <= 1'b0;
      j           <= 1'b0;
      k           <= 1'b0;
      drive_valid <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else begin
      st          <= st_nxt;
      q_exp       <= q_nxt;
      j           <= j_nxt;
      k           <= k_nxt;
      drive_valid <= dv_nxt;
      if (push) begin
        mem[wp] <= tgt_bit;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (clr_err) begin
        err <= 1'b0;
      end else if (mis) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef JK_DRV_COVER_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cov_hold <= '0;
      cov_rst  <= '0;
      cov_set  <= '0;
      cov_tog  <= '0;
    end else if (drive_valid) begin
      case ({j, k})
        2'b00:   if (cov_hold != 16'hFFFF) cov_hold <= cov_hold + 16'd1;
        2'b01:   if (cov_rst  != 16'hFFFF) cov_rst  <= cov_rst  + 16'd1;
        2'b10:   if (cov_set  != 16'hFFFF) cov_set  <= cov_set  + 16'd1;
        default: if (cov_tog  != 16'hFFFF) cov_tog  <= cov_tog  + 16'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver. Two instances share stimulus:
//   d0: TOGGLE_MODE=0, HALT_ON_ERR=1   d1: TOGGLE_MODE=1, HALT_ON_ERR=0
// Each drives its own behavioural JK flop whose q comes back on q_fb
// (optionally overridden to inject mismatches). A queue-based reference
// model tracks every output cycle by cycle; directed sections add fixed
// expectations for the documented scenarios.
module tb_jk_excite_driver;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rstn, en, tgt_valid, tgt_bit, clr_err, force_en, force_val;
  logic       fq[2], qfb[2];
  logic       oj[2], ok[2], odv[2], oerr[2], ordy[2];
  logic [7:0] ocnt[2];
  logic [3:0] olev[2];

  always #5 clk = !clk;

  jk_excite_driver #(.DEPTH(DEPTH), .TOGGLE_MODE(0), .HALT_ON_ERR(1)) d0 (
    .clk(clk), .rstn(rstn), .en(en), .tgt_valid(tgt_valid), .tgt_ready(ordy[0]),
    .tgt_bit(tgt_bit), .q_fb(qfb[0]), .clr_err(clr_err), .j(oj[0]), .k(ok[0]),
    .drive_valid(odv[0]), .err(oerr[0]), .err_cnt(ocnt[0]), .level(olev[0]));

  jk_excite_driver #(.DEPTH(DEPTH), .TOGGLE_MODE(1), .HALT_ON_ERR(0)) d1 (
    .clk(clk), .rstn(rstn), .en(en), .tgt_valid(tgt_valid), .tgt_ready(ordy[1]),
    .tgt_bit(tgt_bit), .q_fb(qfb[1]), .clr_err(clr_err), .j(oj[1]), .k(ok[1]),
    .drive_valid(odv[1]), .err(oerr[1]), .err_cnt(ocnt[1]), .level(olev[1]));

  function automatic logic jk(input logic q, input logic jj, input logic kk);
    if (jj && kk) return !q;
    if (jj)       return 1'b1;
    if (kk)       return 1'b0;
    return q;
  endfunction

  // the flops being driven
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq[0] <= 1'b0;
      fq[1] <= 1'b0;
    end else begin
      fq[0] <= jk(fq[0], oj[0], ok[0]);
      fq[1] <= jk(fq[1], oj[1], ok[1]);
    end
  end
  assign qfb[0] = force_en ? force_val : fq[0];
  assign qfb[1] = force_en ? force_val : fq[1];

  // ---------------- reference model ----------------
  int  nrun = 0, nfail = 0;
  bit  mq[2][$];
  bit  mj[2], mk[2], mdv[2], mqe[2], merr[2];
  int  mcnt[2];
  int  mst[2];                 // 0 idle, 1 drive, 2 halt
  int  sq[2][$];               // captured driven j/k codes
  bit  fqs[2][$];              // flop q after each driven code

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mj[m] = 0; mk[m] = 0; mdv[m] = 0; mqe[m] = 0; merr[m] = 0;
      mcnt[m] = 0; mst[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    bit dc, mis, qn, pop, tb, push;
    int nst;
    dc   = (m == 1);
    push = tgt_valid && (mq[m].size() < DEPTH);
    mis  = (qfb[m] != mqe[m]);
    qn   = clr_err ? qfb[m] : jk(mqe[m], mj[m], mk[m]);
    pop  = 0;
    nst  = mst[m];
    if (!clr_err && mis && m == 0) nst = 2;
    else if (mst[m] == 0) begin if (en) nst = 1; end
    else if (mst[m] == 1) begin
      if (!en) nst = 0;
      else if (mq[m].size() > 0) pop = 1;
    end else if (clr_err) nst = 0;
    mj[m] = 0; mk[m] = 0; mdv[m] = pop;
    if (pop) begin
      tb = mq[m].pop_front();
      case ({qn, tb})
        2'b00: begin mj[m] = 0;  mk[m] = dc; end
        2'b01: begin mj[m] = 1;  mk[m] = dc; end
        2'b10: begin mj[m] = dc; mk[m] = 1;  end
        2'b11: begin mj[m] = dc; mk[m] = 0;  end
      endcase
    end
    if (push) mq[m].push_back(tgt_bit);
    if (clr_err) merr[m] = 0;
    else if (mis) begin
      merr[m] = 1;
      if (mcnt[m] < 255) mcnt[m]++;
    end
    mqe[m] = qn;
    mst[m] = nst;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d.j", m),     16'(oj[m]),   16'(mj[m]));
      chk($sformatf("d%0d.k", m),     16'(ok[m]),   16'(mk[m]));
      chk($sformatf("d%0d.dv", m),    16'(odv[m]),  16'(mdv[m]));
      chk($sformatf("d%0d.err", m),   16'(oerr[m]), 16'(merr[m]));
      chk($sformatf("d%0d.cnt", m),   16'(ocnt[m]), 16'(mcnt[m]));
      chk($sformatf("d%0d.level", m), 16'(olev[m]), 16'(mq[m].size()));
      chk($sformatf("d%0d.ready", m), 16'(ordy[m]), 16'(mq[m].size() < DEPTH));
    end
  endtask

  // one clock: model consumes pre-edge inputs, DUT checked just after the edge
  task automatic step();
    bit pdv[2];
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      pdv[m] = odv[m];
      model_step(m);
    end
    @(posedge clk);
    #1;
    check_all();
    for (int m = 0; m < 2; m++) begin
      if (odv[m]) sq[m].push_back({oj[m], ok[m]});
      if (pdv[m]) fqs[m].push_back(fq[m]);
    end
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rstn = 1'b1;
  endtask

  int ndv;
  int exp_jk[2][5] = '{'{2, 0, 1, 0, 2}, '{3, 2, 3, 1, 3}};
  bit exp_q[5] = '{1, 1, 0, 0, 1};
  bit seq_bits[5] = '{1, 1, 0, 0, 1};

  initial begin
    rstn = 1'b0; en = 1'b1; tgt_valid = 1'b1; tgt_bit = 1'b1;
    clr_err = 1'b0; force_en = 1'b0; force_val = 1'b0;
    model_reset();
    // reset held across an edge with valid and en high
    @(posedge clk); #1;
    check_all();
    #1 rstn = 1'b1;
    tgt_valid = 1'b0;

    // back-to-back targets 1,1,0,0,1
    for (int m = 0; m < 2; m++) begin sq[m].delete(); fqs[m].delete(); end
    for (int i = 0; i < 9; i++) begin
      tgt_valid = (i < 5);
      tgt_bit   = (i < 5) ? seq_bits[i] : 1'b0;
      step();
    end
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d.ndrv", m), 16'(sq[m].size()), 16'd5);
      for (int i = 0; i < 5 && i < sq[m].size(); i++)
        chk($sformatf("d%0d.jk%0d", m, i), 16'(sq[m][i]), 16'(exp_jk[m][i]));
      for (int i = 0; i < 5 && i < fqs[m].size(); i++)
        chk($sformatf("d%0d.q%0d", m, i), 16'(fqs[m][i]), 16'(exp_q[i]));
      chk($sformatf("d%0d.seq_err", m), 16'(oerr[m]), 16'd0);
    end

    // fill while disabled, then release
    en = 1'b0; tgt_valid = 1'b1; step();        // DRIVE -> IDLE
    tgt_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin tgt_bit = 1'($urandom); step(); end
    chk("fill.level", 16'(olev[0]), 16'd8);
    chk("fill.ready", 16'(ordy[0]), 16'd0);
    en = 1'b1; step();                          // IDLE -> DRIVE
    chk("fill.ready_e1", 16'(ordy[0]), 16'd0);
    step();                                     // first pop
    chk("fill.level_pop", 16'(olev[0]), 16'd7);
    chk("fill.ready_pop", 16'(ordy[0]), 16'd1);
    step();                                     // 9th accepted
    chk("fill.level_9th", 16'(olev[0]), 16'd7);
    tgt_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // forced mismatch / halt / clr_err
    async_reset();
    en = 1'b1; step();
    force_en = 1'b1; force_val = 1'b1; step();
    chk("halt.err", 16'(oerr[0]), 16'd1);
    chk("halt.cnt", 16'(ocnt[0]), 16'd1);
    chk("halt.jk",  16'({oj[0], ok[0]}), 16'd0);
    clr_err = 1'b1; step();
    clr_err = 1'b0;
    chk("clr.err", 16'(oerr[0]), 16'd0);
    chk("clr.cnt", 16'(ocnt[0]), 16'd1);
    en = 1'b0; step();                          // q_exp resynced to 1
    chk("resync.err", 16'(oerr[0]), 16'd0);
    force_en = 1'b0; clr_err = 1'b1; step();    // back to real q
    clr_err = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // reset mid-stream after 3 of 6 driven
    en = 1'b0; tgt_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin tgt_bit = 1'($urandom); step(); end
    tgt_valid = 1'b0; en = 1'b1; step();
    ndv = 0;
    for (int i = 0; i < 3; i++) begin step(); ndv += odv[0]; end
    chk("mid.ndv3", 16'(ndv), 16'd3);
    async_reset();
    chk("mid.level", 16'(olev[0]), 16'd0);
    for (int i = 0; i < 6; i++) begin step(); ndv += odv[0]; end
    chk("mid.ndv_after", 16'(ndv), 16'd3);

    // err_cnt saturation
    force_en = 1'b1; force_val = 1'b1;
    for (int i = 0; i < 260; i++) step();
    chk("sat.cnt0", 16'(ocnt[0]), 16'd255);
    chk("sat.cnt1", 16'(ocnt[1]), 16'd255);
    force_en = 1'b0; clr_err = 1'b1; step(); clr_err = 1'b0;
    async_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tgt_valid = ($urandom_range(3) != 0);
      tgt_bit   = 1'($urandom);
      en        = ($urandom_range(7) != 0);
      clr_err   = ($urandom_range(15) == 0);
      force_en  = ($urandom_range(19) == 0);
      force_val = 1'($urandom);
      if ($urandom_range(99) == 0) async_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
